// File: rtl/bcd_counter_n_pkg.sv
// Shared BCD digit constants and the digit-valid check used by the load path.
package bcd_counter_n_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: load, increment or decrement with 9<->0 roll, plus ripple flags.
module bcd_digit
    import bcd_counter_n_pkg::*;
(
    input  logic               clk,
    input  logic               rst_asyn,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] value,
    output logic               at_max,
    output logic               at_min
);

    assign at_max = (value == BCD_MAX);
    assign at_min = (value == BCD_MIN);

    always_ff @(posedge clk) begin
        if (rst_asyn) begin
            value <= BCD_MIN;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= at_max ? BCD_MIN : value + 4'd1;
        end else if (dec) begin
            value <= at_min ? BCD_MAX : value - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-decade BCD up/down counter with validated load, carry/borrow pulse and
// selectable wrap or saturate behaviour at the terminal value.
module bcd_counter_n
    import bcd_counter_n_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_asyn,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] Q_out,
    output logic                    co,
    output logic                    tc,
    output logic                    load_err
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] dec;
    logic [DIGITS:0]   max_chain;
    logic [DIGITS:0]   min_chain;

    logic load_ok;
    logic do_load;
    logic load_bad;
    logic step;
    logic at_term;
    logic blocked;
    logic count_up;
    logic count_dn;
    logic co_next;

    // All lower decades at 9 (or 0) enables decade i; index DIGITS is the whole count.
    always_comb begin
        max_chain[0] = 1'b1;
        min_chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            max_chain[i+1] = max_chain[i] & at_max[i];
            min_chain[i+1] = min_chain[i] & at_min[i];
        end
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            load_ok = load_ok & digit_valid(load_val[DIGIT_W*i +: DIGIT_W]);
        end
    end

    // A rejected load still consumes the cycle, so en is ignored whenever load is high.
    assign do_load  = load & load_ok;
    assign load_bad = load & ~load_ok;
    assign step     = en & ~load;

    assign at_term  = up ? max_chain[DIGITS] : min_chain[DIGITS];
    assign blocked  = ~WRAP & at_term;
    assign count_up = step & up & ~blocked;
    assign count_dn = step & ~up & ~blocked;
    assign co_next  = (count_up | count_dn) & at_term;

    assign inc = {DIGITS{count_up}} & max_chain[DIGITS-1:0];
    assign dec = {DIGITS{count_dn}} & min_chain[DIGITS-1:0];

    assign tc = at_term;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_asyn (rst_asyn),
            .inc      (inc[g]),
            .dec      (dec[g]),
            .load     (do_load),
            .load_val (load_val[DIGIT_W*g +: DIGIT_W]),
            .value    (Q_out[DIGIT_W*g +: DIGIT_W]),
            .at_max   (at_max[g]),
            .at_min   (at_min[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_asyn) begin
            co       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            co       <= co_next;
            load_err <= load_bad;
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Two-decade bench: a wrapping and a saturating counter share stimulus; an
// integer-valued model predicts each cycle and a monitor compares from queues.
module tb_bcd_counter_n;

    localparam int DIGITS = 2;
    localparam int QW     = 4 * DIGITS;
    localparam int W      = QW + 3;
    localparam int MAXV   = 99;

    logic          clk;
    logic          rst_asyn;
    logic          en;
    logic          up;
    logic          load;
    logic [QW-1:0] load_val;

    logic [QW-1:0] q_w, q_s;
    logic          co_w, co_s, tc_w, tc_s, err_w, err_s;

    logic [W-1:0] exp_q_w[$];
    logic [W-1:0] exp_q_s[$];

    int checks = 0;
    int errors = 0;
    int mv_w   = 0;
    int mv_s   = 0;

    bcd_counter_n #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_wrap (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .Q_out    (q_w),
        .co       (co_w),
        .tc       (tc_w),
        .load_err (err_w)
    );

    bcd_counter_n #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_sat (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .Q_out    (q_s),
        .co       (co_s),
        .tc       (tc_s),
        .load_err (err_s)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_asyn = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
    end

    // reference model (plain decimal integers)
    function automatic logic [QW-1:0] to_bcd(input int v);
        logic [QW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [QW-1:0] lv);
        for (int i = 0; i < DIGITS; i++) begin
            if (lv[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [QW-1:0] lv);
        int v;
        int m;
        v = 0;
        m = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v = v + int'(lv[4*i +: 4]) * m;
            m = m * 10;
        end
        return v;
    endfunction

    task automatic model_step(input bit wrap, input logic r, input logic l,
                              input logic [QW-1:0] lv, input logic e, input logic u,
                              input int v_in, output int v_out, output logic [W-1:0] exp);
        logic c;
        logic er;
        logic t;
        int v;
        v  = v_in;
        c  = 1'b0;
        er = 1'b0;
        if (r) begin
            v = 0;
        end else if (l) begin
            if (bcd_ok(lv)) v = from_bcd(lv);
            else            er = 1'b1;
        end else if (e) begin
            if (u) begin
                if (v == MAXV) begin
                    if (wrap) begin v = 0; c = 1'b1; end
                end else begin
                    v = v + 1;
                end
            end else begin
                if (v == 0) begin
                    if (wrap) begin v = MAXV; c = 1'b1; end
                end else begin
                    v = v - 1;
                end
            end
        end
        t     = u ? (v == MAXV) : (v == 0);
        v_out = v;
        exp   = {t, er, c, to_bcd(v)};
    endtask

    // driver
    task automatic drive(input logic r, input logic l, input logic [QW-1:0] lv,
                         input logic e, input logic u);
        logic [W-1:0] ew;
        logic [W-1:0] es;
        @(negedge clk);
        rst_asyn = r;
        load     = l;
        load_val = lv;
        en       = e;
        up       = u;
        model_step(1'b1, r, l, lv, e, u, mv_w, mv_w, ew);
        model_step(1'b0, r, l, lv, e, u, mv_s, mv_s, es);
        exp_q_w.push_back(ew);
        exp_q_s.push_back(es);
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_w.size() > 0) begin
                e = exp_q_w.pop_front();
                checks++;
                if ({tc_w, err_w, co_w, q_w} !== e) begin
                    errors++;
                    $display("FAIL wrap_dut t=%0t got q=%h co=%b err=%b tc=%b expected q=%h co=%b err=%b tc=%b",
                             $time, q_w, co_w, err_w, tc_w, e[QW-1:0], e[QW], e[QW+1], e[QW+2]);
                end
            end
            if (exp_q_s.size() > 0) begin
                e = exp_q_s.pop_front();
                checks++;
                if ({tc_s, err_s, co_s, q_s} !== e) begin
                    errors++;
                    $display("FAIL sat_dut t=%0t got q=%h co=%b err=%b tc=%b expected q=%h co=%b err=%b tc=%b",
                             $time, q_s, co_s, err_s, tc_s, e[QW-1:0], e[QW], e[QW+1], e[QW+2]);
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [QW-1:0] lv;
        logic          r, l, e, u;

        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // reset mid-count
        drive(1'b0, 1'b1, 8'h36, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

        // up ripple through terminal
        drive(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // down borrow
        drive(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // saturate vs wrap at 99, then reverse direction
        drive(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // rejected load
        drive(1'b0, 1'b1, 8'h42, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 8'h3A, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 8'hA3, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // priority: reset > load > en
        drive(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 5))
                0: lv = 8'h99;
                1: lv = 8'h00;
                2: lv = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
                default: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            endcase
            drive(r, l, lv, e, u);
        end

        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q_w.size() != 0 || exp_q_s.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d expected 0/0", exp_q_w.size(), exp_q_s.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised multi-decade BCD counter, successor to the single-digit 0–9 counter.
- Adds DIGITS-wide cascading, up/down counting, count enable, validated parallel load, carry/borrow output and selectable wrap/saturate mode.
- Sits beside display/timer logic as the decimal time-base and event-count source.
- Single clock domain; all state changes on rising clk.

Parameters:
- DIGITS, 4, number of BCD decades (1..8); Q_out width = 4*DIGITS.
- WRAP, 1, 1 = roll over at terminal value; 0 = saturate at terminal value.

Ports:
- clk  input  1  system clock, rising edge.
- rst_asyn  input  1  reset; synchronous, active-high, sampled on rising clk.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load request.
- load_val  input  4*DIGITS  BCD value to load; digit i = bits [4i+3:4i].
- Q_out  output  4*DIGITS  registered BCD count, digit 0 least significant.
- co  output  1  registered one-cycle carry/borrow pulse on roll-over.
- tc  output  1  combinational terminal count: all 9s when up=1, all 0s when up=0.
- load_err  output  1  registered one-cycle pulse: load rejected.

Behaviour:
- Reset: Q_out=0, co=0, load_err=0, so tc=0 when up=1 and tc=1 when up=0.
- Reset takes effect on the next rising edge and overrides everything, including a count or load in flight.
- Priority per cycle: rst_asyn > load > en. Idle (none active) holds Q_out; co and load_err are 0.
- Load, all digits of load_val <= 9: Q_out=load_val on the next edge, co=0, load_err=0.
- Load, any digit > 9: Q_out unchanged, load_err=1 for one cycle, co=0. en is ignored that cycle.
- Up count (en=1, up=1):
  - Digit i increments when all lower digits are 9; a digit at 9 goes to 0.
  - Full ripple resolves in the same cycle, so latency is 1 clock.
- Down count (en=1, up=0):
  - Digit i decrements when all lower digits are 0; a digit at 0 goes to 9.
- Terminal count, WRAP=1: up at all 9s gives all 0s; down at all 0s gives all 9s. co=1 in the cycle the wrapped value appears on Q_out.
- Terminal count, WRAP=0: Q_out holds at the terminal value and co stays 0.
- Direction change while tc=1: tc is re-evaluated immediately against the new up value.
- co and load_err are never high together, and never high in consecutive cycles unless re-triggered.
- Q_out never holds a non-BCD digit after reset.

Decomposition:
- Shared include bcd_defs.vh holds:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0;
  - DIGIT_W = 4;
  - a digit-valid check macro for the load test.
- One sub-module, bcd_digit: a single decade with inc, dec, load and a 4-bit value.
  - Outputs at_max and at_min for ripple.
  - Instantiated DIGITS times with a generate loop.
  - The top level ANDs the at_max/at_min chains to form per-digit enables, tc and co.

Test Plan (DIGITS=2 unless stated):
- Reset in the middle of a count: rst_asyn high for 1 cycle at Q_out=8'h37 -> Q_out=8'h00 next edge, co=0.
- Up ripple with WRAP=1: load 8'h98, en=1, up=1 for 3 cycles -> Q_out 8'h99 (tc=1), then 8'h00 with co=1, then 8'h01 with co=0.
- Down borrow: load 8'h10, en=1, up=0 -> 8'h09, 8'h08; from 8'h00 next step gives 8'h99 with co=1.
- Saturate, WRAP=0: count up from 8'h99 for 3 cycles -> Q_out stays 8'h99, co=0, tc=1; switch up=0 -> tc=0 and the next step gives 8'h98.
- Bad load: load_val=8'h3A with load=1 and en=1 while Q_out=8'h42 -> Q_out stays 8'h42, load_err=1 for exactly one cycle.
- Priority: load=1 with load_val=8'h55, en=1, rst_asyn=1 -> Q_out=8'h00; next cycle the same without reset -> Q_out=8'h55, not 8'h56.
